pl_exception_unit: RTL and testbench
====================================

// Module: pl_exception_unit
// PURPOSE
//  Multi-cause precise exception/interrupt unit for the pipelined MIPS core.
//  - Replaces the two-cause undefined/overflow handler.
//  - Prioritises 6 synchronous causes plus NUM_IRQ level-sensitive interrupts.
//  - Keeps EPC/Cause/BadVAddr/Status(EXL,IE,IM) state.
//  - Sequences pipeline flush and PC redirect through an FSM; handles ERET.
//  - Sits beside the hazard unit: the FSM drives flush, and redirect_pc feeds the PC mux.
// PARAMETERS
//  NUM_IRQ       6             number of external interrupt lines (1..8)
//  FLUSH_CYCLES  2             cycles flush is held before redirect (>=1)
//  EXC_VECTOR    32'h0000_0180 handler address for synchronous exceptions
//  IRQ_VECTOR    32'h0000_0200 handler address for interrupts
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        synchronous, active-high
//  enable       in   1        pipeline advance; detection sampled only when 1
//  exc_adel     in   1        load/fetch address error
//  exc_ri       in   1        reserved/undefined instruction (control | alu_control)
//  exc_sys      in   1        syscall
//  exc_bp       in   1        break
//  exc_ovf      in   1        arithmetic overflow
//  exc_ades     in   1        store address error
//  bad_addr     in   32       faulting address for exc_adel/exc_ades
//  pc_current   in   32       PC of the instruction carrying the causes
//  eret         in   1        ERET in the detect stage
//  irq          in   NUM_IRQ  level interrupt requests
//  status_we    in   1        write IE/IM (MTC0 Status)
//  status_wdata in   NUM_IRQ+1  {IM[NUM_IRQ-1:0], IE}
//  flush        out  1        squash IF..EX stages
//  pc_redirect  out  1        one-cycle pulse: load redirect_pc into PC
//  redirect_pc  out  32       target PC (vector or EPC)
//  epc_reg      out  32       exception PC
//  cause_code   out  5        ExcCode of last taken event
//  cause_ip     out  NUM_IRQ  registered irq & IM
//  bad_vaddr    out  32       BadVAddr
//  exl          out  1        exception level
//  ie           out  1        global interrupt enable
//  im           out  NUM_IRQ  interrupt mask
//  busy         out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset values: all outputs 0, except im = all-ones.
//  Reset mid-sequence returns the FSM to IDLE immediately; no redirect is issued.
//  Event evaluation: only in IDLE with enable=1.
//  Event priority (ExcCode):
//  - AdEL(4) > RI(10) > Sys(8) > Bp(9) > Ov(12) > AdES(5) > ERET > Int(0).
//  - Int is taken if ie & ~exl & |(irq & im).
//  On a taken exception or interrupt:
//  - cause_code is set.
//  - bad_vaddr <= bad_addr for AdEL/AdES only.
//  - epc_reg <= pc_current only if exl==0; nested exceptions keep EPC.
//  - exl <= 1.
//  - target <= IRQ_VECTOR for Int, else EXC_VECTOR.
//  On ERET: target <= epc_reg; exl is cleared in the REDIRECT cycle. ERET with exl=0 is ignored.
//  Sync exceptions and ERET in the same cycle: the exception wins; ERET is dropped.
//  FSM states:
//  - IDLE: event taken -> FLUSH, cnt <= FLUSH_CYCLES-1.
//  - FLUSH: flush=1; cnt==0 -> REDIRECT, else cnt-1. Runs regardless of enable.
//  - REDIRECT: flush=1, pc_redirect=1, redirect_pc=target -> IDLE.
//  Latency: event sampled at edge N -> flush high for cycles N+1..N+FLUSH_CYCLES+1;
//  pc_redirect pulses in cycle N+FLUSH_CYCLES+1.
//  Causes and ERET arriving while busy=1 are ignored (squashed instructions).
//  status_we applies in any state; when it coincides with exception entry, the IE/IM write still occurs.
//  cause_ip is updated every cycle, independent of state.
//  Pending irq stays pending while masked; it is taken on the first IDLE cycle after unmasking or exl clearing.
// TESTING
//  (FLUSH_CYCLES=2)
//  - exc_ovf=1, pc_current=0x0040_0010 -> flush high 3 cycles;
//    pc_redirect on 3rd cycle with redirect_pc=0x180; epc=0x0040_0010, cause_code=12, exl=1.
//  - exc_adel+exc_ri+exc_ovf together, bad_addr=0x1003 -> cause_code=4, bad_vaddr=0x1003.
//  - exl=1, exc_sys at pc 0x500 -> redirect 0x180, cause_code=8, epc unchanged.
//    Then eret -> redirect to old epc, exl=0 after the redirect cycle.
//  - ie=1, im=6'b000100, irq=6'b000100 -> redirect 0x200, cause_code=0, cause_ip=6'b000100;
//    with im=0 -> no event, cause_ip=0.
//  - Reset asserted in FLUSH -> next cycle flush=0, busy=0, no pc_redirect; exl=0, epc=0.
//  - eret with exc_bp in the same cycle -> cause_code=9, redirect 0x180.
//    exc_ri during FLUSH -> ignored.

Source files
------------

// File: rtl/pl_exception_unit.sv
// rtl/pl_exception_unit.sv - precise multi-cause exception/interrupt unit with flush/redirect FSM
module pl_exception_unit #(
  parameter int          NUM_IRQ      = 6,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               exc_adel,
  input  logic               exc_ri,
  input  logic               exc_sys,
  input  logic               exc_bp,
  input  logic               exc_ovf,
  input  logic               exc_ades,
  input  logic [31:0]        bad_addr,
  input  logic [31:0]        pc_current,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               status_we,
  input  logic [NUM_IRQ:0]   status_wdata,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc_reg,
  output logic [4:0]         cause_code,
  output logic [NUM_IRQ-1:0] cause_ip,
  output logic [31:0]        bad_vaddr,
  output logic               exl,
  output logic               ie,
  output logic [NUM_IRQ-1:0] im,
  output logic               busy
);

  // Counter only has to hold FLUSH_CYCLES-1.
  localparam int                CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        target_q, target_d;
  logic               eret_q, eret_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;
  logic [NUM_IRQ-1:0] cause_ip_q, cause_ip_d;
  logic [31:0]        badv_q, badv_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] im_q, im_d;

  logic       sync_any;
  logic [4:0] sync_code;
  logic       sync_addr_err;
  logic       evaluate;
  logic       take_sync;
  logic       take_eret;
  logic       take_int;

  // Fixed-priority selection of the synchronous cause code.
  always_comb begin
    sync_code = 5'd0;
    if (exc_adel)      sync_code = 5'd4;
    else if (exc_ri)   sync_code = 5'd10;
    else if (exc_sys)  sync_code = 5'd8;
    else if (exc_bp)   sync_code = 5'd9;
    else if (exc_ovf)  sync_code = 5'd12;
    else if (exc_ades) sync_code = 5'd5;
  end

  assign sync_any      = exc_adel | exc_ri | exc_sys | exc_bp | exc_ovf | exc_ades;
  assign sync_addr_err = (sync_code == 5'd4) || (sync_code == 5'd5);
  assign evaluate      = (state_q == ST_IDLE) && enable;
  // A sync exception squashes a simultaneous ERET; ERET outside EXL is a no-op.
  assign take_sync     = evaluate && sync_any;
  assign take_eret     = evaluate && !sync_any && eret && exl_q;
  assign take_int      = evaluate && !sync_any && !(eret && exl_q) &&
                         ie_q && !exl_q && (|(irq & im_q));

  // Next-state for the sequencing FSM and the architectural CP0 state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    eret_d     = eret_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    badv_d     = badv_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    im_d       = im_q;
    cause_ip_d = irq & im_q;

    case (state_q)
      ST_IDLE: begin
        if (take_sync || take_eret || take_int) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_REDIRECT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
        // ERET leaves exception level only once the return redirect is issued.
        if (eret_q) exl_d = 1'b0;
        eret_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_sync || take_int) begin
      cause_d  = take_sync ? sync_code : 5'd0;
      target_d = take_sync ? EXC_VECTOR : IRQ_VECTOR;
      eret_d   = 1'b0;
      exl_d    = 1'b1;
      // Nested exceptions keep the original return address.
      if (!exl_q) epc_d = pc_current;
      if (take_sync && sync_addr_err) badv_d = bad_addr;
    end

    if (take_eret) begin
      target_d = epc_q;
      eret_d   = 1'b1;
    end

    // Status writes land regardless of FSM state or a coincident exception.
    if (status_we) begin
      ie_d = status_wdata[0];
      im_d = status_wdata[NUM_IRQ:1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      target_q   <= '0;
      eret_q     <= 1'b0;
      epc_q      <= '0;
      cause_q    <= '0;
      cause_ip_q <= '0;
      badv_q     <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      im_q       <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      eret_q     <= eret_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      cause_ip_q <= cause_ip_d;
      badv_q     <= badv_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      im_q       <= im_d;
    end
  end

  assign flush       = (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign pc_redirect = (state_q == ST_REDIRECT);
  assign redirect_pc = (state_q == ST_REDIRECT) ? target_q : 32'h0;
  assign epc_reg     = epc_q;
  assign cause_code  = cause_q;
  assign cause_ip    = cause_ip_q;
  assign bad_vaddr   = badv_q;
  assign exl         = exl_q;
  assign ie          = ie_q;
  assign im          = im_q;

endmodule

// File: tb/tb_pl_exception_unit.sv
// tb/tb_pl_exception_unit.sv - self-checking bench for pl_exception_unit
module tb_pl_exception_unit;
  localparam int          NIRQ  = 6;
  localparam int          FC    = 2;
  localparam logic [31:0] EXC_V = 32'h0000_0180;
  localparam logic [31:0] IRQ_V = 32'h0000_0200;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            exc_adel = 1'b0, exc_ri = 1'b0, exc_sys = 1'b0;
  logic            exc_bp = 1'b0, exc_ovf = 1'b0, exc_ades = 1'b0;
  logic [31:0]     bad_addr = '0, pc_current = '0;
  logic            eret = 1'b0;
  logic [NIRQ-1:0] irq = '0;
  logic            status_we = 1'b0;
  logic [NIRQ:0]   status_wdata = '0;
  logic            flush, pc_redirect, busy, exl, ie;
  logic [31:0]     redirect_pc, epc_reg, bad_vaddr;
  logic [4:0]      cause_code;
  logic [NIRQ-1:0] cause_ip, im;

  pl_exception_unit #(
    .NUM_IRQ(NIRQ), .FLUSH_CYCLES(FC), .EXC_VECTOR(EXC_V), .IRQ_VECTOR(IRQ_V)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .exc_adel(exc_adel), .exc_ri(exc_ri), .exc_sys(exc_sys), .exc_bp(exc_bp),
    .exc_ovf(exc_ovf), .exc_ades(exc_ades), .bad_addr(bad_addr), .pc_current(pc_current),
    .eret(eret), .irq(irq), .status_we(status_we), .status_wdata(status_wdata),
    .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .epc_reg(epc_reg), .cause_code(cause_code), .cause_ip(cause_ip),
    .bad_vaddr(bad_vaddr), .exl(exl), .ie(ie), .im(im), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Architectural reference state.
  logic [31:0]     m_epc, m_badv;
  logic [4:0]      m_cause;
  logic            m_exl, m_ie;
  logic [NIRQ-1:0] m_im;
  bit              exp_taken;
  logic [31:0]     exp_target;

  // Observed sequence for the last event.
  int              obs_flush, obs_red, obs_red_idx;
  logic [31:0]     obs_pc;
  logic            obs_exl_red;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {exc_ades, exc_ovf, exc_bp, exc_sys, exc_ri, exc_adel} = 6'b0;
    eret = 1'b0;
    enable = 1'b0;
    status_we = 1'b0;
  endtask

  task automatic model_reset();
    m_epc = '0; m_badv = '0; m_cause = '0; m_exl = 1'b0; m_ie = 1'b0; m_im = '1;
  endtask

  // Causes vector order: {ades, ovf, bp, sys, ri, adel}; index 0 is highest priority.
  task automatic model_event(input logic [5:0] c, input logic er, input logic en,
                             input logic [NIRQ-1:0] iq, input logic [31:0] pc,
                             input logic [31:0] ba, input logic swe, input logic [NIRQ:0] swd);
    int codes[6];
    int hit;
    codes = '{4, 10, 8, 9, 12, 5};
    hit = -1;
    exp_taken = 1'b0;
    if (en) begin
      for (int i = 0; i < 6; i++) if (c[i] && hit < 0) hit = i;
      if (hit >= 0) begin
        exp_taken = 1'b1;
        m_cause = 5'(codes[hit]);
        if (hit == 0 || hit == 5) m_badv = ba;
        if (!m_exl) m_epc = pc;
        m_exl = 1'b1;
        exp_target = EXC_V;
      end else if (er && m_exl) begin
        exp_taken = 1'b1;
        exp_target = m_epc;
        m_exl = 1'b0;
      end else if (m_ie && !m_exl && ((iq & m_im) != 0)) begin
        exp_taken = 1'b1;
        m_cause = 5'd0;
        m_epc = pc;
        m_exl = 1'b1;
        exp_target = IRQ_V;
      end
    end
    if (swe) begin
      m_ie = swd[0];
      m_im = swd[NIRQ:1];
    end
  endtask

  // Presents one IDLE-cycle stimulus, then follows the sequence to its end.
  task automatic do_event(input logic [5:0] c, input logic er, input logic en,
                          input logic [NIRQ-1:0] iq, input logic [31:0] pc,
                          input logic [31:0] ba, input logic swe, input logic [NIRQ:0] swd,
                          input bit junk);
    {exc_ades, exc_ovf, exc_bp, exc_sys, exc_ri, exc_adel} = c;
    eret = er; enable = en; irq = iq; pc_current = pc; bad_addr = ba;
    status_we = swe; status_wdata = swd;
    step();
    clear_inputs();
    obs_flush = 0; obs_red = 0; obs_red_idx = 0; obs_pc = '0; obs_exl_red = 1'b0;
    for (int k = 1; k <= 20 && busy; k++) begin
      if (flush) obs_flush++;
      if (pc_redirect) begin
        obs_red++; obs_red_idx = k; obs_pc = redirect_pc; obs_exl_red = exl;
      end
      if (junk) begin
        {exc_ades, exc_ovf, exc_bp, exc_sys, exc_ri, exc_adel} = 6'($urandom) | 6'b000010;
        eret = 1'($urandom); enable = 1'($urandom);
        pc_current = $urandom; bad_addr = $urandom;
      end
      step();
      clear_inputs();
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
    n_cmp++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL reset_pc_redirect: got %b expected 0", pc_redirect); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    n_cmp++; if (epc_reg !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", epc_reg); end
    n_cmp++; if (cause_code !== 5'd0) begin n_fail++; $display("FAIL reset_cause: got %0d expected 0", cause_code); end
    n_cmp++; if (cause_ip !== '0) begin n_fail++; $display("FAIL reset_cause_ip: got %b expected 0", cause_ip); end
    n_cmp++; if (bad_vaddr !== 32'h0) begin n_fail++; $display("FAIL reset_bad_vaddr: got %h expected 0", bad_vaddr); end
    n_cmp++; if ({exl, ie, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_exl_ie_busy: got %b expected 000", {exl, ie, busy}); end
    n_cmp++; if (im !== 6'b111111) begin n_fail++; $display("FAIL reset_im: got %b expected 111111", im); end
    reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_ovf();
    model_event(6'b010000, 0, 1, '0, 32'h0040_0010, 32'h0, 0, '0);
    do_event(6'b010000, 0, 1, '0, 32'h0040_0010, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_flush !== FC + 1) begin n_fail++; $display("FAIL ovf_flush_cycles: got %0d expected %0d", obs_flush, FC + 1); end
    n_cmp++; if (obs_red !== 1 || obs_red_idx !== FC + 1) begin n_fail++; $display("FAIL ovf_redirect_timing: got %0d pulses at %0d expected 1 at %0d", obs_red, obs_red_idx, FC + 1); end
    n_cmp++; if (obs_pc !== 32'h180) begin n_fail++; $display("FAIL ovf_redirect_pc: got %h expected 00000180", obs_pc); end
    n_cmp++; if (epc_reg !== 32'h0040_0010) begin n_fail++; $display("FAIL ovf_epc: got %h expected 00400010", epc_reg); end
    n_cmp++; if (cause_code !== 5'd12) begin n_fail++; $display("FAIL ovf_cause: got %0d expected 12", cause_code); end
    n_cmp++; if (exl !== 1'b1) begin n_fail++; $display("FAIL ovf_exl: got %b expected 1", exl); end
  endtask

  task automatic test_priority();
    model_event(6'b010011, 0, 1, '0, 32'h0000_0444, 32'h1003, 0, '0);
    do_event(6'b010011, 0, 1, '0, 32'h0000_0444, 32'h1003, 0, '0, 0);
    n_cmp++; if (cause_code !== 5'd4) begin n_fail++; $display("FAIL prio_cause: got %0d expected 4", cause_code); end
    n_cmp++; if (bad_vaddr !== 32'h1003) begin n_fail++; $display("FAIL prio_bad_vaddr: got %h expected 00001003", bad_vaddr); end
    n_cmp++; if (epc_reg !== 32'h0040_0010) begin n_fail++; $display("FAIL prio_epc_kept: got %h expected 00400010", epc_reg); end
  endtask

  task automatic test_nested_eret();
    model_event(6'b000100, 0, 1, '0, 32'h500, 32'h0, 0, '0);
    do_event(6'b000100, 0, 1, '0, 32'h500, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_pc !== 32'h180) begin n_fail++; $display("FAIL nest_redirect_pc: got %h expected 00000180", obs_pc); end
    n_cmp++; if (cause_code !== 5'd8) begin n_fail++; $display("FAIL nest_cause: got %0d expected 8", cause_code); end
    n_cmp++; if (epc_reg !== 32'h0040_0010) begin n_fail++; $display("FAIL nest_epc: got %h expected 00400010", epc_reg); end
    model_event(6'b0, 1, 1, '0, 32'h504, 32'h0, 0, '0);
    do_event(6'b0, 1, 1, '0, 32'h504, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_flush !== FC + 1 || obs_pc !== 32'h0040_0010) begin n_fail++; $display("FAIL eret_redirect: got %0d cycles pc %h expected %0d pc 00400010", obs_flush, obs_pc, FC + 1); end
    n_cmp++; if (obs_exl_red !== 1'b1) begin n_fail++; $display("FAIL eret_exl_in_redirect: got %b expected 1", obs_exl_red); end
    n_cmp++; if (exl !== 1'b0) begin n_fail++; $display("FAIL eret_exl_after: got %b expected 0", exl); end
  endtask

  task automatic test_interrupt();
    model_event(6'b0, 0, 0, '0, 32'h0, 32'h0, 1, {6'b000100, 1'b1});
    do_event(6'b0, 0, 0, '0, 32'h0, 32'h0, 1, {6'b000100, 1'b1}, 0);
    model_event(6'b0, 0, 1, 6'b000100, 32'h600, 32'h0, 0, '0);
    do_event(6'b0, 0, 1, 6'b000100, 32'h600, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_pc !== 32'h200 || obs_red !== 1) begin n_fail++; $display("FAIL int_redirect: got pc %h pulses %0d expected 00000200 1", obs_pc, obs_red); end
    n_cmp++; if (cause_code !== 5'd0 || epc_reg !== 32'h600) begin n_fail++; $display("FAIL int_cause_epc: got %0d %h expected 0 00000600", cause_code, epc_reg); end
    n_cmp++; if (cause_ip !== 6'b000100) begin n_fail++; $display("FAIL int_cause_ip: got %b expected 000100", cause_ip); end
    // Mask the line, return, and confirm the still-asserted irq stays pending.
    model_event(6'b0, 0, 0, 6'b000100, 32'h0, 32'h0, 1, {6'b000000, 1'b1});
    do_event(6'b0, 0, 0, 6'b000100, 32'h0, 32'h0, 1, {6'b000000, 1'b1}, 0);
    n_cmp++; if (cause_ip !== 6'b000000) begin n_fail++; $display("FAIL int_masked_cause_ip: got %b expected 000000", cause_ip); end
    model_event(6'b0, 1, 1, 6'b000100, 32'h604, 32'h0, 0, '0);
    do_event(6'b0, 1, 1, 6'b000100, 32'h604, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_pc !== 32'h600 || exl !== 1'b0) begin n_fail++; $display("FAIL int_eret: got pc %h exl %b expected 00000600 0", obs_pc, exl); end
    model_event(6'b0, 0, 1, 6'b000100, 32'h700, 32'h0, 0, '0);
    do_event(6'b0, 0, 1, 6'b000100, 32'h700, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_flush !== 0) begin n_fail++; $display("FAIL int_masked_no_event: got %0d flush cycles expected 0", obs_flush); end
    model_event(6'b0, 0, 1, 6'b000100, 32'h704, 32'h0, 1, {6'b000100, 1'b1});
    do_event(6'b0, 0, 1, 6'b000100, 32'h704, 32'h0, 1, {6'b000100, 1'b1}, 0);
    model_event(6'b0, 0, 1, 6'b000100, 32'h708, 32'h0, 0, '0);
    do_event(6'b0, 0, 1, 6'b000100, 32'h708, 32'h0, 0, '0, 0);
    n_cmp++; if (obs_pc !== 32'h200 || epc_reg !== 32'h708) begin n_fail++; $display("FAIL int_unmask_taken: got pc %h epc %h expected 00000200 00000708", obs_pc, epc_reg); end
    irq = '0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    clear_inputs();
    {exc_ovf, enable} = 2'b11; pc_current = 32'h900;
    step();
    clear_inputs();
    step();
    reset = 1'b1;
    step();
    n_cmp++; if ({flush, busy, pc_redirect} !== 3'b000) begin n_fail++; $display("FAIL rstmid_fsm: got flush/busy/redirect %b expected 000", {flush, busy, pc_redirect}); end
    n_cmp++; if (exl !== 1'b0 || epc_reg !== 32'h0) begin n_fail++; $display("FAIL rstmid_state: got exl %b epc %h expected 0 00000000", exl, epc_reg); end
    reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (pc_redirect || flush) pulses++;
      step();
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_no_redirect: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_eret_vs_bp();
    model_event(6'b000010, 0, 1, '0, 32'h800, 32'h0, 0, '0);
    do_event(6'b000010, 0, 1, '0, 32'h800, 32'h0, 0, '0, 0);
    model_event(6'b001000, 1, 1, '0, 32'h804, 32'h0, 0, '0);
    do_event(6'b001000, 1, 1, '0, 32'h804, 32'h0, 0, '0, 1);
    n_cmp++; if (cause_code !== 5'd9) begin n_fail++; $display("FAIL eretbp_cause: got %0d expected 9", cause_code); end
    n_cmp++; if (obs_pc !== 32'h180 || obs_red !== 1) begin n_fail++; $display("FAIL eretbp_redirect: got pc %h pulses %0d expected 00000180 1", obs_pc, obs_red); end
    n_cmp++; if (epc_reg !== 32'h800 || exl !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL eretbp_state: got epc %h exl %b busy %b expected 00000800 1 0", epc_reg, exl, busy); end
  endtask

  task automatic test_random();
    logic [5:0]      c;
    logic            er, en, swe;
    logic [NIRQ-1:0] iq;
    logic [NIRQ:0]   swd;
    logic [31:0]     pc, ba;
    reset = 1'b1; step(); reset = 1'b0; model_reset();
    for (int it = 0; it < 200; it++) begin
      c = '0;
      for (int b = 0; b < 6; b++) c[b] = ($urandom_range(0, 7) == 0);
      er  = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 9) != 0);
      iq  = ($urandom_range(0, 1) == 0) ? '0 : NIRQ'($urandom);
      swe = ($urandom_range(0, 4) == 0);
      swd = (NIRQ + 1)'($urandom);
      pc  = {$urandom} & 32'hFFFF_FFFC;
      ba  = $urandom;
      model_event(c, er, en, iq, pc, ba, swe, swd);
      do_event(c, er, en, iq, pc, ba, swe, swd, 1);
      n_cmp++; if (obs_flush !== (exp_taken ? FC + 1 : 0) || obs_red !== (exp_taken ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_sequence: got %0d flush %0d redirect expected taken=%0d", it, obs_flush, obs_red, exp_taken); end
      n_cmp++; if (exp_taken && obs_pc !== exp_target) begin n_fail++; $display("FAIL rnd%0d_target: got %h expected %h", it, obs_pc, exp_target); end
      n_cmp++; if ({epc_reg, bad_vaddr, cause_code} !== {m_epc, m_badv, m_cause}) begin n_fail++; $display("FAIL rnd%0d_regs: got epc %h badv %h cause %0d expected %h %h %0d", it, epc_reg, bad_vaddr, cause_code, m_epc, m_badv, m_cause); end
      n_cmp++; if ({exl, ie, im, cause_ip} !== {m_exl, m_ie, m_im, iq & m_im}) begin n_fail++; $display("FAIL rnd%0d_status: got exl %b ie %b im %b ip %b expected %b %b %b %b", it, exl, ie, im, cause_ip, m_exl, m_ie, m_im, iq & m_im); end
    end
    irq = '0;
  endtask

  initial begin
    test_reset();
    test_ovf();
    test_priority();
    test_nested_eret();
    test_interrupt();
    test_reset_mid();
    test_eret_vs_bp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1);
  end

endmodule
